// File: rtl/seg_2_dff.sv
// seg_2_dff: enabled D-type register written as two segments, a combinational
// next-state segment and a clocked state-register segment. It serves as a
// generic storage or retiming element for control and datapath bits.
//
// Parameters:
//   WIDTH    bit width of d, q and chg (at least 1)
//   RST_VAL  value loaded into q while reset is asserted
//
// Ports:
//   clk      clock; all state updates happen on the rising edge
//   reset    asynchronous, active-high reset
//   en       load enable; 1 captures d at the next rising edge
//   d        data input
//   q        registered data output
//   chg      per-bit "q changed at the last edge" flag. This port is present
//            only when the macro SEG_2_DFF_CHG_EN is defined.
//
// Optional feature macro: SEG_2_DFF_CHG_EN

module seg_2_dff #(
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
`ifdef SEG_2_DFF_CHG_EN
    output logic [WIDTH-1:0] chg,
`endif
    output logic [WIDTH-1:0] q
);

    // Next-state segment: hold unless enabled.
    logic [WIDTH-1:0] q_next;

    always_comb begin
        q_next = q;
        if (en) begin
            q_next = d;
        end
    end

    // Register segment. The path from d to q is registered only. A reset that
    // is still high at an edge wins, so the edge coinciding with release loads
    // nothing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RST_VAL;
        end else begin
            q <= q_next;
        end
    end

`ifdef SEG_2_DFF_CHG_EN
    // Flags the bits that flip at this edge. A flag stays high for exactly the
    // one cycle in which q shows the new value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chg <= '0;
        end else begin
            chg <= q_next ^ q;
        end
    end
`endif

endmodule

// File: tb/tb_seg_2_dff.sv
// tb_seg_2_dff: scoreboard bench for seg_2_dff.
// Two instances are tested: WIDTH=1 with RST_VAL=0, and WIDTH=8 with RST_VAL=8'hA5.
// The driver works out the expected post-edge state from the register rules
// and queues it. The monitor checks the outputs one time unit after each edge.

module tb_seg_2_dff;

    localparam logic [7:0] RST8 = 8'hA5;

    logic       clk;
    logic       reset;
    logic       en;
    logic       d1;
    logic [7:0] d8;
    logic       q1;
    logic [7:0] q8;
`ifdef SEG_2_DFF_CHG_EN
    logic       c1;
    logic [7:0] c8;
`endif

    seg_2_dff #(
        .WIDTH   (1),
        .RST_VAL (1'b0)
    ) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .d     (d1),
`ifdef SEG_2_DFF_CHG_EN
        .chg   (c1),
`endif
        .q     (q1)
    );

    seg_2_dff #(
        .WIDTH   (8),
        .RST_VAL (RST8)
    ) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .d     (d8),
`ifdef SEG_2_DFF_CHG_EN
        .chg   (c8),
`endif
        .q     (q8)
    );

    initial clk = 1'b0;
    always #2 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       q1;
        logic [7:0] q8;
        logic       c1;
        logic [7:0] c8;
    } exp_t;

    exp_t sb[$];

    // Reference state: the value each register should hold, and which bits
    // flipped at the most recent edge.
    logic       m_q1;
    logic [7:0] m_q8;
    logic       m_c1;
    logic [7:0] m_c8;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Apply one rising edge to the reference and queue the result.
    task automatic model_edge();
        exp_t       e;
        logic       n1;
        logic [7:0] n8;
        if (reset) begin
            n1   = 1'b0;
            n8   = RST8;
            m_c1 = 1'b0;
            m_c8 = 8'h00;
        end else begin
            n1   = en ? d1 : m_q1;
            n8   = en ? d8 : m_q8;
            m_c1 = n1 ^ m_q1;
            m_c8 = n8 ^ m_q8;
        end
        m_q1 = n1;
        m_q8 = n8;
        e.q1 = m_q1;
        e.q8 = m_q8;
        e.c1 = m_c1;
        e.c8 = m_c8;
        sb.push_back(e);
    endtask

    // Runs one clock cycle and is entered at a falling edge. The reset input
    // is always driven with nonblocking assignments, like a registered reset.
    // When rel is set, reset falls at the rising edge itself, after the DUT
    // has sampled it high. When wig is set, d also toggles in the high phase.
    task automatic cycle(input logic r, input logic e, input logic dd1, input logic [7:0] dd8,
                         input bit rel, input bit wig);
        reset <= r;
        en     = e;
        d1     = dd1;
        d8     = dd8;
        @(posedge clk);
        model_edge();
        if (rel) begin
            reset <= 1'b0;
        end
        if (wig) begin
            #1;
            d1 = ~d1;
            d8 = ~d8;
        end
        @(negedge clk);
    endtask

    // Asserts reset at a falling edge and checks q a moment later, before any
    // rising edge has occurred.
    task automatic async_reset();
        reset <= 1'b1;
        #1;
        check("async_q1", {7'd0, q1}, 8'h00);
        check("async_q8", q8, RST8);
`ifdef SEG_2_DFF_CHG_EN
        check("async_c8", c8, 8'h00);
`endif
        m_q1 = 1'b0;
        m_q8 = RST8;
        m_c1 = 1'b0;
        m_c8 = 8'h00;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // Monitor: checks each queued expectation one time unit after its edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("q1", {7'd0, q1}, {7'd0, e.q1});
                check("q8", q8, e.q8);
`ifdef SEG_2_DFF_CHG_EN
                check("chg1", {7'd0, c1}, {7'd0, e.c1});
                check("chg8", c8, e.c8);
`endif
            end
        end
    end

    initial begin
        reset <= 1'b1;
        en     = 1'b0;
        d1     = 1'b0;
        d8     = 8'h00;
        m_q1   = 1'b0;
        m_q8   = RST8;
        m_c1   = 1'b0;
        m_c8   = 8'h00;

        // Hold reset while en and d are active.
        repeat (3) cycle(1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
        // Release reset exactly at an edge; that edge loads nothing.
        cycle(1'b1, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0);
        // A5 -> 5A flips every bit of the 8-bit instance.
        cycle(1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
        // q1 0->1; the identical 5A reload leaves chg8 at 0.
        cycle(1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
        // Reload of 1 leaves chg1 at 0.
        cycle(1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
        // Hold with d toggling every half cycle.
        repeat (4) cycle(1'b0, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1);
        // Asynchronous reset with q1=1.
        async_reset();
        // Release at an edge with en=1, d=1; the load happens one edge later.
        cycle(1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            int unsigned k;
            k = $urandom_range(31);
            if (k == 0) begin
                async_reset();
            end else if (reset && k < 16) begin
                cycle(1'b1, 1'($urandom), 1'($urandom), 8'($urandom), 1'b1, 1'b0);
            end else begin
                cycle(k == 1, 1'($urandom), 1'($urandom), 8'($urandom), 1'b0, k[1] & k[2]);
            end
        end

        repeat (2) @(negedge clk);
        check("drain", 8'(sb.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
